// File: rtl/adc_pkg.sv
// Shared definitions for the ADC settle/measure scanner.
// Holds the controller state codes and the monitor bus bit positions.
// No logic here; the package is imported by the controller and its bench.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_BAD     = 2'd3
    } adc_state_e;

    localparam int MON_START    = 0;
    localparam int MON_BUSY     = 1;
    localparam int MON_LATCH    = 2;
    localparam int MON_VALID    = 3;
    localparam int MON_STATE_LO = 4;
    localparam int MON_STATE_HI = 5;

endpackage

// File: rtl/adc_countdown.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Latency: load/decrement visible the cycle after the request.
// No backpressure: load has priority over decrement, both act every cycle.
module adc_countdown #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise step down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/adc_scan.sv
// ADC mux settle/measure controller, single channel or wrapping scan.
// Latency: valid in cycle S+D+3 after accept; each further scan channel S+D+2 later.
// No backpressure: start ignored while busy and in the cycle done first rises; abort always wins.
module adc_scan
    import adc_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int N_CHAN = 4,
    parameter int MUX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adc_measure_start,
    input  logic             adc_abort,
    input  logic [CNT_W-1:0] clk_settle_duration,
    input  logic [CNT_W-1:0] clk_sample_duration,
    input  logic             scan_mode,
    input  logic [MUX_W-1:0] chan_first,
    input  logic [MUX_W-1:0] chan_last,
    output logic             adc_measure_done,
    output logic             adc_measure_valid,
    output logic [MUX_W-1:0] chan_tag,
    output logic [MUX_W-1:0] adcmux,
    output logic             cmpr_latch,
    output logic             busy,
    output logic [5:0]       monitor
);

    adc_state_e       state_q, state_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             latch_q, latch_d;
    logic             cool_q, cool_d;
    logic [MUX_W-1:0] mux_q, mux_d;
    logic [MUX_W-1:0] tag_q, tag_d;
    logic [MUX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] s_q, s_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             scan_q, scan_d;
    logic [5:0]       mon_q, mon_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             accept;

    // Out-of-range channel numbers fall back to channel 0.
    function automatic logic [MUX_W-1:0] clamp_chan(input logic [MUX_W-1:0] c);
        return (32'(c) >= N_CHAN) ? '0 : c;
    endfunction

    // The first IDLE cycle after a job (cool_q) is a one-cycle gap before a new accept.
    assign accept = (state_q == ST_IDLE) && adc_measure_start && !adc_abort && !cool_q;

    adc_countdown #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, counter control and output decisions; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        valid_d  = 1'b0;
        latch_d  = latch_q;
        cool_d   = 1'b0;
        mux_d    = mux_q;
        tag_d    = tag_q;
        last_d   = last_q;
        s_d      = s_q;
        dur_d    = dur_q;
        scan_d   = scan_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = s_q;
        if (adc_abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            latch_d = 1'b0;
            cool_d  = (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d  = ST_SETTLE;
                        done_d   = 1'b0;
                        latch_d  = 1'b1;
                        mux_d    = clamp_chan(chan_first);
                        last_d   = clamp_chan(chan_last);
                        s_d      = clk_settle_duration;
                        dur_d    = clk_sample_duration;
                        scan_d   = scan_mode;
                        cnt_load = 1'b1;
                        cnt_val  = clk_settle_duration;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state_d  = ST_MEASURE;
                        latch_d  = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = dur_q;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (cnt_zero) begin
                        valid_d = 1'b1;
                        tag_d   = mux_q;
                        if (!scan_q || (mux_q == last_q)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            cool_d  = 1'b1;
                        end else begin
                            state_d  = ST_SETTLE;
                            latch_d  = 1'b1;
                            mux_d    = (32'(mux_q) == N_CHAN - 1) ? '0 : mux_q + MUX_W'(1);
                            cnt_load = 1'b1;
                            cnt_val  = s_q;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    latch_d = 1'b0;
                end
            endcase
        end
        mon_d                             = '0;
        mon_d[MON_START]                  = accept;
        mon_d[MON_BUSY]                   = (state_d != ST_IDLE);
        mon_d[MON_LATCH]                  = latch_d;
        mon_d[MON_VALID]                  = valid_d;
        mon_d[MON_STATE_HI:MON_STATE_LO]  = state_d;
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            cool_q  <= 1'b0;
            mux_q   <= '0;
            tag_q   <= '0;
            last_q  <= '0;
            s_q     <= '0;
            dur_q   <= '0;
            scan_q  <= 1'b0;
            mon_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            latch_q <= latch_d;
            cool_q  <= cool_d;
            mux_q   <= mux_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
            s_q     <= s_d;
            dur_q   <= dur_d;
            scan_q  <= scan_d;
            mon_q   <= mon_d;
        end
    end

    assign adc_measure_done  = done_q;
    assign adc_measure_valid = valid_q;
    assign chan_tag          = tag_q;
    assign adcmux            = mux_q;
    assign cmpr_latch        = latch_q;
    assign busy              = (state_q != ST_IDLE);
    assign monitor           = mon_q;

endmodule

// File: tb/tb_adc_scan.sv
// Bench for adc_scan: job-level timing model compared every cycle, plus directed literal checks.
module tb_adc_scan;
    import adc_pkg::*;

    localparam int CNT_W  = 32;
    localparam int N_CHAN = 4;
    localparam int MUX_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             adc_measure_start;
    logic             adc_abort;
    logic [CNT_W-1:0] clk_settle_duration;
    logic [CNT_W-1:0] clk_sample_duration;
    logic             scan_mode;
    logic [MUX_W-1:0] chan_first;
    logic [MUX_W-1:0] chan_last;
    logic             adc_measure_done;
    logic             adc_measure_valid;
    logic [MUX_W-1:0] chan_tag;
    logic [MUX_W-1:0] adcmux;
    logic             cmpr_latch;
    logic             busy;
    logic [5:0]       monitor;

    adc_scan #(.CNT_W(CNT_W), .N_CHAN(N_CHAN), .MUX_W(MUX_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .adc_measure_start   (adc_measure_start),
        .adc_abort           (adc_abort),
        .clk_settle_duration (clk_settle_duration),
        .clk_sample_duration (clk_sample_duration),
        .scan_mode           (scan_mode),
        .chan_first          (chan_first),
        .chan_last           (chan_last),
        .adc_measure_done    (adc_measure_done),
        .adc_measure_valid   (adc_measure_valid),
        .chan_tag            (chan_tag),
        .adcmux              (adcmux),
        .cmpr_latch          (cmpr_latch),
        .busy                (busy),
        .monitor             (monitor)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit model_on = 0;

    // Job record: accept cycle, latched durations, channel list, abort cycle (-1 none).
    int j_act = 0;
    int j_acc, j_S, j_D, j_n;
    int j_abort = -1;
    int j_ch[16];
    int base_mux = 0;
    int base_tag = 0;

    int vq_c[$];
    int vq_t[$];
    int lq[$];
    int dq[$];
    int busy_cnt = 0;
    bit prev_done = 1'b1;
    int acc, acc2;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Each channel occupies S+1 settle cycles followed by D+1 measure cycles.
    function automatic int m_per();
        return j_S + j_D + 2;
    endfunction

    // First cycle after the job in which the controller is idle again.
    function automatic int m_stop();
        if (j_abort >= 0) return j_abort + 1;
        return j_acc + 1 + j_n * m_per();
    endfunction

    function automatic bit m_busy(input int c);
        if (j_act == 0) return 1'b0;
        return (c >= j_acc + 1) && (c < m_stop());
    endfunction

    function automatic bit m_cool(input int c);
        return (j_act != 0) && (c == m_stop());
    endfunction

    function automatic bit m_valid(input int c);
        int r;
        if (j_act == 0) return 1'b0;
        r = c - j_acc - 1;
        if (r <= 0 || (r % m_per()) != 0 || (r / m_per()) > j_n) return 1'b0;
        if (j_abort >= 0 && c > j_abort) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_mux(input int c);
        if (j_act == 0 || c <= j_acc) return base_mux;
        if (m_busy(c)) return j_ch[(c - j_acc - 1) / m_per()];
        if (j_abort >= 0) return j_ch[(j_abort - j_acc - 1) / m_per()];
        return j_ch[j_n - 1];
    endfunction

    function automatic int m_tag(input int c);
        int lim, kd;
        if (j_act == 0) return base_tag;
        lim = c;
        if (j_abort >= 0 && j_abort < lim) lim = j_abort;
        if (lim < j_acc + 1 + m_per()) return base_tag;
        kd = (lim - j_acc - 1) / m_per();
        if (kd > j_n) kd = j_n;
        return j_ch[kd - 1];
    endfunction

    function automatic bit m_latch(input int c);
        return m_busy(c) && (((c - j_acc - 1) % m_per()) <= j_S);
    endfunction

    function automatic int m_state(input int c);
        if (!m_busy(c)) return 0;
        return m_latch(c) ? 1 : 2;
    endfunction

    function automatic int m_mon(input int c);
        int st;
        st = m_state(c);
        return st * 16 + int'(m_valid(c)) * 8 + int'(m_latch(c)) * 4 + int'(m_busy(c)) * 2
             + int'((j_act != 0) && (c == j_acc + 1));
    endfunction

    // Model update from the inputs of the cycle that is ending.
    always @(posedge clk) begin
        int fc, lc;
        if (reset) begin
            j_act    = 0;
            j_abort  = -1;
            base_mux = 0;
            base_tag = 0;
            model_on = 1;
        end else if (model_on) begin
            if (adc_abort) begin
                if (m_busy(cyc)) j_abort = cyc;
            end else if (adc_measure_start && !m_busy(cyc) && !m_cool(cyc)) begin
                base_mux = m_mux(cyc);
                base_tag = m_tag(cyc);
                fc = (int'(chan_first) >= N_CHAN) ? 0 : int'(chan_first);
                lc = (int'(chan_last) >= N_CHAN) ? 0 : int'(chan_last);
                j_n = scan_mode ? ((lc - fc + N_CHAN) % N_CHAN) + 1 : 1;
                for (int k = 0; k < j_n; k++) j_ch[k] = (fc + k) % N_CHAN;
                j_S     = int'(clk_settle_duration);
                j_D     = int'(clk_sample_duration);
                j_acc   = cyc;
                j_abort = -1;
                j_act   = 1;
            end
        end
        cyc++;
    end

    // Compare every output against the model each cycle and log events for literal checks.
    always @(negedge clk) begin
        if (model_on) begin
            cmp("done",    int'(adc_measure_done),  int'(!m_busy(cyc)));
            cmp("valid",   int'(adc_measure_valid), int'(m_valid(cyc)));
            cmp("chan_tag", int'(chan_tag),         m_tag(cyc));
            cmp("adcmux",  int'(adcmux),            m_mux(cyc));
            cmp("latch",   int'(cmpr_latch),        int'(m_latch(cyc)));
            cmp("busy",    int'(busy),              int'(m_busy(cyc)));
            cmp("monitor", int'(monitor),           m_mon(cyc));
            if (adc_measure_valid) begin
                vq_c.push_back(cyc);
                vq_t.push_back(int'(chan_tag));
            end
            if (cmpr_latch) lq.push_back(cyc);
            if (adc_measure_done && !prev_done) dq.push_back(cyc);
            if (busy) busy_cnt++;
            prev_done = adc_measure_done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr();
        vq_c.delete();
        vq_t.delete();
        lq.delete();
        dq.delete();
        busy_cnt = 0;
    endtask

    task automatic job(input int s, input int d, input bit sc, input int f, input int l);
        clk_settle_duration = CNT_W'(s);
        clk_sample_duration = CNT_W'(d);
        scan_mode           = sc;
        chan_first          = MUX_W'(f);
        chan_last           = MUX_W'(l);
        adc_measure_start   = 1'b1;
    endtask

    initial begin
        reset = 1'b1; adc_measure_start = 1'b0; adc_abort = 1'b0;
        clk_settle_duration = '0; clk_sample_duration = '0;
        scan_mode = 1'b0; chan_first = '0; chan_last = '0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        cmp("rst_done", int'(adc_measure_done), 1);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_mon", int'(monitor), 0);
        cmp("rst_mux", int'(adcmux), 0);
        tick(2);

        // Single channel 3, S=2 D=5; inputs change after accept and must be ignored.
        clr(); job(2, 5, 1'b0, 3, 0); acc = cyc;
        tick(1); adc_measure_start = 1'b0; clk_settle_duration = 9; chan_first = 1;
        tick(14);
        cmp("A_nvalid", vq_c.size(), 1);
        cmp("A_vcyc", qat(vq_c, 0) - acc, 10);
        cmp("A_tag", qat(vq_t, 0), 3);
        cmp("A_latch_n", lq.size(), 3);
        cmp("A_latch_first", qat(lq, 0) - acc, 1);
        cmp("A_done", qat(dq, 0) - acc, 10);

        // Scan 2 -> 1 wrapping on four channels, S=0 D=1.
        clr(); job(0, 1, 1'b1, 2, 1); acc = cyc;
        tick(1); adc_measure_start = 1'b0; scan_mode = 1'b0;
        tick(16);
        cmp("B_nvalid", vq_c.size(), 4);
        cmp("B_v0", qat(vq_c, 0) - acc, 4);
        cmp("B_v1", qat(vq_c, 1) - acc, 7);
        cmp("B_v2", qat(vq_c, 2) - acc, 10);
        cmp("B_v3", qat(vq_c, 3) - acc, 13);
        cmp("B_t0", qat(vq_t, 0), 2);
        cmp("B_t1", qat(vq_t, 1), 3);
        cmp("B_t2", qat(vq_t, 2), 0);
        cmp("B_t3", qat(vq_t, 3), 1);
        cmp("B_done_n", dq.size(), 1);
        cmp("B_done", qat(dq, 0) - acc, 13);

        // S=D=0 with start held high: one job every 4 cycles.
        clr(); job(0, 0, 1'b0, 1, 0); acc = cyc;
        tick(9); adc_measure_start = 1'b0;
        tick(6);
        cmp("C_nvalid", vq_c.size(), 3);
        cmp("C_v0", qat(vq_c, 0) - acc, 3);
        cmp("C_v1", qat(vq_c, 1) - acc, 7);
        cmp("C_v2", qat(vq_c, 2) - acc, 11);

        // Abort in the 4th MEASURE cycle of D=9, then a normal job.
        clr(); job(1, 9, 1'b0, 2, 0); acc = cyc;
        tick(1); adc_measure_start = 1'b0;
        tick(5); adc_abort = 1'b1;
        tick(1); adc_abort = 1'b0;
        tick(1); job(0, 0, 1'b0, 1, 0); acc2 = cyc;
        tick(1); adc_measure_start = 1'b0;
        tick(6);
        cmp("D_abort_done", qat(dq, 0) - acc, 7);
        cmp("D_nvalid", vq_c.size(), 1);
        cmp("D_v0", qat(vq_c, 0) - acc2, 3);
        cmp("D_t0", qat(vq_t, 0), 1);

        // Start while busy is ignored; start+abort together in IDLE is ignored.
        clr(); job(3, 3, 1'b0, 2, 0); acc = cyc;
        tick(1); adc_measure_start = 1'b0;
        tick(2); adc_measure_start = 1'b1; chan_first = 0;
        tick(1); adc_measure_start = 1'b0;
        tick(8);
        cmp("E_nvalid", vq_c.size(), 1);
        cmp("E_v0", qat(vq_c, 0) - acc, 9);
        cmp("E_t0", qat(vq_t, 0), 2);
        tick(2);
        clr(); adc_measure_start = 1'b1; adc_abort = 1'b1;
        tick(1); adc_measure_start = 1'b0; adc_abort = 1'b0;
        tick(6);
        cmp("E_sa_nvalid", vq_c.size(), 0);
        cmp("E_sa_busy", busy_cnt, 0);

        // Out-of-range first channel clamps to 0: scan 7(->0) .. 1.
        clr(); job(1, 1, 1'b1, 7, 1); acc = cyc;
        tick(1); adc_measure_start = 1'b0;
        tick(12);
        cmp("F_nvalid", vq_c.size(), 2);
        cmp("F_v0", qat(vq_c, 0) - acc, 5);
        cmp("F_t0", qat(vq_t, 0), 0);
        cmp("F_v1", qat(vq_c, 1) - acc, 9);
        cmp("F_t1", qat(vq_t, 1), 1);

        // Reset in the middle of a scan, then a start in the first cycle after reset.
        job(2, 2, 1'b1, 0, 3); acc = cyc;
        tick(1); adc_measure_start = 1'b0;
        tick(7); reset = 1'b1;
        tick(1); reset = 1'b0;
        clr(); job(0, 0, 1'b0, 2, 0); acc2 = cyc;
        @(negedge clk);
        cmp("G_done", int'(adc_measure_done), 1);
        cmp("G_valid", int'(adc_measure_valid), 0);
        cmp("G_mux", int'(adcmux), 0);
        cmp("G_tag", int'(chan_tag), 0);
        cmp("G_latch", int'(cmpr_latch), 0);
        cmp("G_mon", int'(monitor), 0);
        tick(1); adc_measure_start = 1'b0;
        tick(5);
        cmp("G_nvalid", vq_c.size(), 1);
        cmp("G_v0", qat(vq_c, 0) - acc2, 3);
        cmp("G_t0", qat(vq_t, 0), 2);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
